// File: rtl/mem_byte_loader_pkg.sv
// Shared types and constants for the byte-stream to memory loader.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } loader_state_t;

  localparam logic [3:0] WSTRB_FULL = 4'b1111;
  localparam logic [3:0] WSTRB_NONE = 4'b0000;

  // Word addresses ignore the two low byte-offset bits.
  function automatic logic [31:0] align_word(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_byte_loader_if.sv
// Control, byte-stream and memory-bus signals of the loader.
// master = the side driving the loader (control, byte source, memory),
// slave  = the loader itself.
interface mem_byte_loader_if;

  logic        load_start;
  logic [31:0] load_base;
  logic [15:0] load_len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  checksum;

  modport master (
    output load_start, load_base, load_len, in_valid, in_data, mem_ready,
    input  in_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
           busy, done, error, checksum
  );

  modport slave (
    input  load_start, load_base, load_len, in_valid, in_data, mem_ready,
    output in_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
           busy, done, error, checksum
  );

endinterface

// File: rtl/mem_byte_loader_byte_packer.sv
// Assembles accepted bytes little-endian into a 32-bit word.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic [1:0]  index,
  output logic        last
);

  assign last = (index == 2'd3);

  // Drop byte k into lane k; clear discards a partial word by rewinding the index.
  always_ff @(posedge clk) begin
    if (reset) begin
      word  <= 32'd0;
      index <= 2'd0;
    end else if (clear) begin
      index <= 2'd0;
    end else if (accept) begin
      word[{index, 3'b000} +: 8] <= in_byte;
      index                      <= index + 2'd1;
    end
  end

endmodule

// File: rtl/mem_byte_loader.sv
// Collects a byte stream into words and writes them to consecutive
// memory addresses, with a per-load checksum and an idle timeout.
module mem_byte_loader
  import loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input logic               clk,
  input logic               reset,
  mem_byte_loader_if.slave  bus
);

  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);

  loader_state_t state;
  loader_state_t state_next;

  logic [31:0] addr;
  logic [15:0] words_left;
  logic [31:0] timer;
  logic [7:0]  csum;
  logic        err;

  logic        accept;
  logic        start_ok;
  logic        timeout;
  logic        write_ack;
  logic        pack_clear;
  logic [31:0] word;
  logic [1:0]  index;
  logic        last;

  assign accept     = bus.in_valid && (state == COLLECT);
  assign pack_clear = start_ok || timeout;

  byte_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .clear   (pack_clear),
    .accept  (accept),
    .in_byte (bus.in_data),
    .word    (word),
    .index   (index),
    .last    (last)
  );

  assign bus.in_ready  = (state == COLLECT);
  assign bus.mem_valid = (state == WRITE);
  assign bus.mem_wstrb = (state == WRITE) ? WSTRB_FULL : WSTRB_NONE;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = word;
  assign bus.busy      = (state == COLLECT) || (state == WRITE);
  assign bus.done      = (state == DONE);
  assign bus.error     = err;
  assign bus.checksum  = csum;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode; an accepted byte always wins over a timeout in the same cycle.
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    timeout    = 1'b0;
    write_ack  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load_start) begin
          start_ok   = 1'b1;
          state_next = (bus.load_len == 16'd0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          if (last) state_next = WRITE;
        end else if ((index != 2'd0) && (timer == TIMER_LAST)) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      WRITE: begin
        if (bus.mem_ready) begin
          write_ack  = 1'b1;
          state_next = (words_left == 16'd1) ? DONE : COLLECT;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Load bookkeeping: address, remaining words, idle timer, checksum, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr       <= 32'd0;
      words_left <= 16'd0;
      timer      <= 32'd0;
      csum       <= 8'd0;
      err        <= 1'b0;
    end else begin
      if (start_ok) begin
        addr       <= align_word(bus.load_base);
        words_left <= bus.load_len;
        timer      <= 32'd0;
        csum       <= 8'd0;
        err        <= 1'b0;
      end
      if (accept) begin
        csum  <= csum + bus.in_data;
        timer <= 32'd0;
      end else if ((state == COLLECT) && (index != 2'd0)) begin
        timer <= timer + 32'd1;
      end
      if (timeout) err <= 1'b1;
      if (write_ack) begin
        addr       <= addr + 32'd4;
        words_left <= words_left - 16'd1;
      end
    end
  end

endmodule

// File: doc/mem_byte_loader.md
MEM_BYTE_LOADER -- requirements
Module: mem_byte_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 25_000_000, max idle cycles between bytes of a partial word (1 s at 25 MHz).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port load_start  input  1  one-cycle pulse; begin a load.
REQ-005 SHALL have port load_base  input  32  word-aligned byte address of first word, sampled with load_start.
REQ-006 SHALL have port load_len  input  16  number of 32-bit words to write, sampled with load_start.
REQ-007 SHALL have port in_valid  input  1  upstream byte stream valid.
REQ-008 SHALL have port in_data  input  8  upstream byte.
REQ-009 SHALL have port in_ready  output  1  loader accepts byte this cycle.
REQ-010 SHALL have port mem_valid  output  1  memory request, bram_controller native bus.
REQ-011 SHALL have port mem_ready  input  1  memory request complete.
REQ-012 SHALL have port mem_addr  output  32  request byte address.
REQ-013 SHALL have port mem_wdata  output  32  write data.
REQ-014 SHALL have port mem_wstrb  output  4  byte enables.
REQ-015 SHALL have port busy  output  1  high from accepted load_start until DONE/ERROR.
REQ-016 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-017 SHALL have port error  output  1  sticky timeout flag; cleared by next accepted load_start or reset.
REQ-018 SHALL have port checksum  output  8  mod-256 sum of bytes accepted in current load.

Function
REQ-019 SHALL implement states IDLE, COLLECT, WRITE, DONE.
REQ-020 IDLE: load_start with load_len!=0 -> COLLECT; latch base, len, clear byte index, checksum, error, timer.
REQ-021 IDLE: load_start with load_len==0 -> DONE; no bus transaction.
REQ-022 load_start outside IDLE SHALL be ignored.
REQ-023 in_ready SHALL be 1 only in COLLECT; byte accepted when in_valid && in_ready.
REQ-024 Bytes SHALL pack little-endian: byte k of word -> wdata[8k+7:8k]; checksum += byte, 8-bit wrap.
REQ-025 On 4th accepted byte -> WRITE next cycle; mem_valid=1, mem_wstrb=4'b1111, mem_addr=current address, held stable until mem_ready.
REQ-026 In WRITE, edge sampling mem_ready=1 SHALL drop mem_valid to 0 same edge (no double write), address += 4, words_left -= 1.
REQ-027 After write: words_left==0 -> DONE, else COLLECT.
REQ-028 DONE SHALL assert done for exactly one cycle, then IDLE; busy low in DONE cycle.
REQ-029 mem_valid SHALL be 0 and mem_wstrb 4'b0000 outside WRITE; mem_ready outside WRITE ignored.
REQ-030 Timer SHALL count cycles in COLLECT with no accepted byte while byte index!=0; reset on each accepted byte.
REQ-031 Timer reaching TIMEOUT_CYCLES SHALL set error, discard partial word, go IDLE; words already written remain.
REQ-032 Address SHALL wrap modulo 2^32; no alignment check beyond masking load_base[1:0] to 0.

Reset
REQ-033 Reset SHALL force IDLE, in_ready=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, done=0, error=0, checksum=0.
REQ-034 Reset mid-WRITE SHALL drop mem_valid at that edge; partial word discarded.

Structure
REQ-035 Package loader_pkg SHALL hold state enum loader_state_t and constant WSTRB_FULL=4'b1111.
REQ-036 One sub-module is natural: byte_packer (byte index counter + 32-bit shift/assemble register).

Verification
REQ-037 load_base=0x10, len=2, bytes 01..08, mem_ready 1 cycle after valid -> writes 0x04030201@0x10, 0x08070605@0x14, done pulse, checksum=0x24.
REQ-038 mem_ready delayed 5 cycles -> mem_valid/addr/wdata stable 5 cycles, single write, in_ready=0 throughout.
REQ-039 load_len=0 -> done pulse 1 cycle after start, mem_valid never 1.
REQ-040 TIMEOUT_CYCLES=16, len=1, send 2 bytes then stop -> error=1 after 16 idle cycles, busy=0, no write.
REQ-041 load_start during COLLECT -> ignored, base unchanged; reset during WRITE -> mem_valid=0 next cycle, state IDLE.
